sram_like_arbiter: RTL and testbench
====================================

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive data grants allowed while an instruction request waits (range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have ports inst_req/inst_wr/inst_size/inst_addr/inst_wdata  input  1/1/2/32/32  instruction-side sram-like request.
REQ-005 SHALL have ports inst_rdata/inst_addr_ok/inst_data_ok  output  32/1/1  instruction-side sram-like response.
REQ-006 SHALL have ports data_req/data_wr/data_size/data_addr/data_wdata  input  1/1/2/32/32  data-side sram-like request.
REQ-007 SHALL have ports data_rdata/data_addr_ok/data_data_ok  output  32/1/1  data-side sram-like response.
REQ-008 SHALL have ports m_req/m_wr/m_size/m_addr/m_wdata  output  1/1/2/32/32  shared bus sram-like request.
REQ-009 SHALL have ports m_rdata/m_addr_ok/m_data_ok  input  32/1/1  shared bus sram-like response.

Function
REQ-010 SHALL keep at most one bus transaction outstanding; states IDLE, WAIT_I, WAIT_D.
REQ-011 IDLE: winner selected combinationally; data wins when both request, unless starve count == STARVE_LIMIT, then inst wins.
REQ-012 IDLE: m_req = winner's req; m_wr/m_size/m_addr/m_wdata = winner's fields; with no requester, m_req=0 and all other m_* outputs 0.
REQ-013 IDLE: m_addr_ok routed to winner's addr_ok only; loser's addr_ok SHALL be 0 in the same cycle.
REQ-014 IDLE, m_req && m_addr_ok: next state WAIT_I (inst winner) or WAIT_D (data winner); otherwise stay IDLE.
REQ-015 A requester dropping req before addr_ok SHALL simply lose the slot; there is no latching of unaccepted requests.
REQ-016 WAIT_x: m_req=0 and all other m_* request outputs 0; m_rdata and m_data_ok routed to side x only; other side's addr_ok, data_ok and rdata SHALL be 0.
REQ-017 WAIT_x, m_data_ok=1: inst/data_data_ok pulses 1 cycle with rdata valid; next state IDLE.
REQ-018 No new request SHALL be issued in the cycle m_data_ok arrives; minimum 2 cycles per transaction, with the next addr handshake at earliest one cycle after data_ok.
REQ-019 m_data_ok in IDLE SHALL be ignored: no response to either side and no state change.
REQ-020 Starve counter, 4 bits: +1 (saturating at STARVE_LIMIT) on each data grant while inst_req=1; cleared on inst grant or whenever inst_req=0 in IDLE.
REQ-021 inst_rdata/data_rdata SHALL be 0 whenever the matching data_ok is 0.

Reset
REQ-022 rst=1 at a clock edge SHALL force IDLE and starve count 0; after the edge all m_* outputs, addr_ok, data_ok and rdata outputs are 0 until a new request.
REQ-023 Reset mid-transaction SHALL abandon the outstanding transfer; a later stray m_data_ok is ignored per REQ-019.

Verification
REQ-024 Single inst read: inst_req=1, addr 0xBFC00000, m_addr_ok same cycle, m_data_ok 3 cycles later with 0x3C08BFC0 -> inst_addr_ok 1 in cycle 0, inst_data_ok 1 in cycle 3 with inst_rdata 0x3C08BFC0, data side all 0.
REQ-025 Simultaneous requests, count 0: both req=1 with addresses 0x1000 (inst) and 0x8000 (data), m_addr_ok=1 -> m_addr=0x8000, data_addr_ok=1, inst_addr_ok=0, state WAIT_D.
REQ-026 Starvation: inst_req held 1, data_req held 1, STARVE_LIMIT=4, 1-cycle bus latency -> 4 data grants then 1 inst grant, pattern repeating.
REQ-027 Data write: data_req=1, data_wr=1, data_size=2'b01, data_addr 0x1002, data_wdata 0x0000ABCD -> m_wr=1, m_size=01, m_addr 0x1002, m_wdata 0x0000ABCD; data_data_ok on bus ack.
REQ-028 Reset in WAIT_D, then m_data_ok=1 in the cycle after reset deasserts -> data_data_ok stays 0, state IDLE, next inst_req granted normally.
REQ-029 Request withdrawn: data_req=1 with m_addr_ok=0 for 2 cycles, then data_req=0 -> no state change; inst_req=1 is then granted immediately.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges an instruction-side and a data-side sram-like
// master onto one shared sram-like bus with at most one transaction in flight.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   inst_req/wr/size/addr/wdata instruction-side request (in)
//   inst_rdata/addr_ok/data_ok  instruction-side response (out)
//   data_req/wr/size/addr/wdata data-side request (in)
//   data_rdata/addr_ok/data_ok  data-side response (out)
//   m_req/wr/size/addr/wdata    shared bus request (out)
//   m_rdata/addr_ok/data_ok     shared bus response (in)
//
// Data normally wins a simultaneous request; after STARVE_LIMIT consecutive
// data grants with an instruction request pending, the instruction side wins.
// Request and response paths are combinational pass-throughs so the addr
// handshake completes in the same cycle the bus accepts it.
module sram_like_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               inst_wins;
  logic               starved;

  // Instruction side wins if it is alone or the data side has used up its quota.
  always_comb begin
    starved   = (starve_q == CNT_W'(STARVE_LIMIT));
    inst_wins = inst_req && (!data_req || starved);
  end

  // State and starvation counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next-state, starvation counter and bus/response routing.
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;

    m_req        = 1'b0;
    m_wr         = 1'b0;
    m_size       = 2'b00;
    m_addr       = '0;
    m_wdata      = '0;

    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;

    case (state_q)
      IDLE: begin
        if (inst_wins) begin
          m_req        = 1'b1;
          m_wr         = inst_wr;
          m_size       = inst_size;
          m_addr       = inst_addr;
          m_wdata      = inst_wdata;
          inst_addr_ok = m_addr_ok;
        end else if (data_req) begin
          m_req        = 1'b1;
          m_wr         = data_wr;
          m_size       = data_size;
          m_addr       = data_addr;
          m_wdata      = data_wdata;
          data_addr_ok = m_addr_ok;
        end

        if (m_req && m_addr_ok) begin
          state_d = inst_wins ? WAIT_I : WAIT_D;
        end

        // Counter only tracks data grants that overtake a waiting inst request.
        if (!inst_req) begin
          starve_d = '0;
        end else if (m_req && m_addr_ok) begin
          if (inst_wins) begin
            starve_d = '0;
          end else if (!starved) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
      end

      WAIT_I: begin
        if (m_data_ok) begin
          inst_data_ok = 1'b1;
          inst_rdata   = DATA_W'(m_rdata);
          state_d      = IDLE;
        end
      end

      WAIT_D: begin
        if (m_data_ok) begin
          data_data_ok = 1'b1;
          data_rdata   = DATA_W'(m_rdata);
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed, table-driven bench for sram_like_arbiter (STARVE_LIMIT = 4).
module tb_sram_like_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok;

  int checks = 0;
  int errors = 0;

  sram_like_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    // stimulus
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic        m_aok;
    logic        m_dok;
    logic [31:0] m_rd;
    // expected
    logic        e_m_req;
    logic [31:0] e_m_addr;
    logic        e_m_wr;
    logic        e_i_aok;
    logic        e_d_aok;
    logic        e_i_dok;
    logic        e_d_dok;
    logic [31:0] e_i_rd;
    logic [31:0] e_d_rd;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tbl [NVEC];

  function automatic vec_t mk(
    input logic i_req, input logic [31:0] i_addr,
    input logic d_req, input logic d_wr, input logic [31:0] d_addr,
    input logic m_aok, input logic m_dok, input logic [31:0] m_rd,
    input logic e_m_req, input logic [31:0] e_m_addr, input logic e_m_wr,
    input logic e_i_aok, input logic e_d_aok,
    input logic e_i_dok, input logic e_d_dok,
    input logic [31:0] e_i_rd, input logic [31:0] e_d_rd);
    vec_t v;
    v.i_req = i_req;   v.i_addr = i_addr;
    v.d_req = d_req;   v.d_wr = d_wr;     v.d_addr = d_addr;
    v.m_aok = m_aok;   v.m_dok = m_dok;   v.m_rd = m_rd;
    v.e_m_req = e_m_req; v.e_m_addr = e_m_addr; v.e_m_wr = e_m_wr;
    v.e_i_aok = e_i_aok; v.e_d_aok = e_d_aok;
    v.e_i_dok = e_i_dok; v.e_d_dok = e_d_dok;
    v.e_i_rd = e_i_rd;   v.e_d_rd = e_d_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'b10; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'b10; data_addr = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    next_cycle();
    next_cycle();
    rst = 0;
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    logic [101:0] got, exp;
    v = tbl[idx];
    inst_req = v.i_req; inst_addr = v.i_addr;
    data_req = v.d_req; data_wr = v.d_wr; data_addr = v.d_addr;
    m_addr_ok = v.m_aok; m_data_ok = v.m_dok; m_rdata = v.m_rd;
    @(negedge clk);
    got = {m_req, m_addr, m_wr, inst_addr_ok, data_addr_ok,
           inst_data_ok, data_data_ok, inst_rdata, data_rdata};
    exp = {v.e_m_req, v.e_m_addr, v.e_m_wr, v.e_i_aok, v.e_d_aok,
           v.e_i_dok, v.e_d_dok, v.e_i_rd, v.e_d_rd};
    chk($sformatf("vec%0d", idx), 128'(got), 128'(exp));
    next_cycle();
  endtask

  initial begin
    //            ireq iaddr         dreq dwr daddr        aok dok rdata
    //            | m_req m_addr      m_wr iaok daok idok ddok irdata        drdata
    // reset state, nothing requested
    tbl[0]  = mk(0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h0,
                 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0);
    // single inst read, accepted at once
    tbl[1]  = mk(1, 32'hBFC00000, 0, 0, 32'h0,    1, 0, 32'h0,
                 1, 32'hBFC00000, 0, 1, 0, 0, 0, 32'h0,        32'h0);
    tbl[2]  = mk(0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h0,
                 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0);
    tbl[3]  = mk(0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h0,
                 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0);
    tbl[4]  = mk(0, 32'h0,        0, 0, 32'h0,    0, 1, 32'h3C08BFC0,
                 0, 32'h0,        0, 0, 0, 1, 0, 32'h3C08BFC0, 32'h0);
    // stray data_ok while idle is ignored
    tbl[5]  = mk(0, 32'h0,        0, 0, 32'h0,    0, 1, 32'h12345678,
                 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0);
    // simultaneous requests: data wins
    tbl[6]  = mk(1, 32'h1000,     1, 0, 32'h8000, 1, 0, 32'h0,
                 1, 32'h8000,     0, 0, 1, 0, 0, 32'h0,        32'h0);
    // WAIT_D: response to data only, no new request while data_ok arrives
    tbl[7]  = mk(1, 32'h1000,     0, 0, 32'h0,    1, 1, 32'h55,
                 0, 32'h0,        0, 0, 0, 0, 1, 32'h0,        32'h55);
    // inst granted the cycle after data_ok
    tbl[8]  = mk(1, 32'h1000,     0, 0, 32'h0,    1, 0, 32'h0,
                 1, 32'h1000,     0, 1, 0, 0, 0, 32'h0,        32'h0);
    // WAIT_I: data request and addr_ok are not passed through
    tbl[9]  = mk(0, 32'h0,        1, 0, 32'h8000, 1, 1, 32'hAA,
                 0, 32'h0,        0, 0, 0, 1, 0, 32'hAA,       32'h0);
    // data request never accepted, then withdrawn
    tbl[10] = mk(0, 32'h0,        1, 0, 32'h8000, 0, 0, 32'h0,
                 1, 32'h8000,     0, 0, 0, 0, 0, 32'h0,        32'h0);
    tbl[11] = mk(0, 32'h0,        1, 0, 32'h8000, 0, 0, 32'h0,
                 1, 32'h8000,     0, 0, 0, 0, 0, 32'h0,        32'h0);
    tbl[12] = mk(1, 32'h1000,     0, 0, 32'h0,    1, 0, 32'h0,
                 1, 32'h1000,     0, 1, 0, 0, 0, 32'h0,        32'h0);
    // rdata held at 0 while data_ok is low, even in WAIT_I
    tbl[13] = mk(0, 32'h0,        0, 0, 32'h0,    0, 0, 32'hDEADBEEF,
                 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0);
    tbl[14] = mk(0, 32'h0,        0, 0, 32'h0,    0, 1, 32'h77,
                 0, 32'h0,        0, 0, 0, 1, 0, 32'h77,       32'h0);
    // data write request presented without acceptance shows m_wr
    tbl[15] = mk(0, 32'h0,        1, 1, 32'h2000, 0, 0, 32'h0,
                 1, 32'h2000,     1, 0, 0, 0, 0, 32'h0,        32'h0);

    do_reset();
    for (int i = 0; i < NVEC; i++) apply_vec(i);

    // Data write: all request fields forwarded, ack routed back on data_ok.
    do_reset();
    data_req = 1; data_wr = 1; data_size = 2'b01;
    data_addr = 32'h1002; data_wdata = 32'h0000ABCD; m_addr_ok = 1;
    @(negedge clk);
    chk("wr_req", 128'({m_req, m_wr, m_size, m_addr, m_wdata, data_addr_ok, inst_addr_ok}),
        128'({1'b1, 1'b1, 2'b01, 32'h1002, 32'h0000ABCD, 1'b1, 1'b0}));
    next_cycle();
    idle_inputs();
    m_data_ok = 1;
    @(negedge clk);
    chk("wr_ack", 128'({m_req, data_data_ok, inst_data_ok, data_rdata}),
        128'({1'b0, 1'b1, 1'b0, 32'h0}));
    next_cycle();

    // Starvation: both sides always requesting, bus answers after one cycle.
    do_reset();
    inst_req = 1; inst_addr = 32'h1000;
    data_req = 1; data_addr = 32'h8000;
    m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'hCAFE;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      chk($sformatf("starve_grant%0d", t), 128'({inst_addr_ok, data_addr_ok}),
          128'(((t % 5) == 4) ? 2'b10 : 2'b01));
      next_cycle();
      @(negedge clk);
      chk($sformatf("starve_resp%0d", t), 128'({m_req, inst_data_ok, data_data_ok}),
          128'(((t % 5) == 4) ? 3'b010 : 3'b001));
      next_cycle();
    end

    // Reset in WAIT_D abandons the transfer; late data_ok goes nowhere.
    do_reset();
    data_req = 1; data_addr = 32'h8000; m_addr_ok = 1;
    next_cycle();
    idle_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
    m_data_ok = 1; m_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("rst_stray", 128'({m_req, data_data_ok, inst_data_ok, data_rdata, inst_rdata,
                           data_addr_ok, inst_addr_ok}), 128'(0));
    next_cycle();
    idle_inputs();
    inst_req = 1; inst_addr = 32'hBFC00000; m_addr_ok = 1;
    @(negedge clk);
    chk("rst_then_inst", 128'({m_req, m_addr, inst_addr_ok, data_addr_ok}),
        128'({1'b1, 32'hBFC00000, 1'b1, 1'b0}));
    next_cycle();
    idle_inputs();
    m_data_ok = 1; m_rdata = 32'h600DF00D;
    @(negedge clk);
    chk("rst_then_inst_resp", 128'({inst_data_ok, inst_rdata, data_data_ok}),
        128'({1'b1, 32'h600DF00D, 1'b0}));
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
